riscv_multicycle_control: RTL and testbench
===========================================

# riscv_multicycle_control

Multi-cycle main control unit for the RV32I datapath. It replaces the single-cycle opcode decoder with a Moore state machine. Each instruction is sequenced through fetch, decode, execute, memory and writeback steps over a shared ALU and a unified memory port. Other additions over the single-cycle decoder:
- optional memory ready handshake with a timeout watchdog;
- sticky error flags;
- a retired-instruction counter.

## Interface
Parameters:
- MEM_HANDSHAKE, 1, 1 = memory states wait for `mem_ready`; 0 = `mem_ready` internally forced to 1.
- MEM_TIMEOUT, 16, maximum cycles spent in one memory-wait state; 0 disables the watchdog.
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- opcode  in  7  instr[6:0] from the instruction register; sampled in DECODE and MEMADR only.
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory access complete this cycle.
- pc_write  out  1  PC load enable.
- adr_src  out  1  0 = PC, 1 = ALUOut drives the memory address.
- mem_read  out  1  memory read strobe.
- mem_write  out  1  memory write strobe.
- ir_write  out  1  instruction register / oldPC load enable.
- result_src  out  2  00 = ALUOut, 01 = memory data, 10 = ALU result.
- alu_src_a  out  2  00 = PC, 01 = oldPC, 10 = rs1.
- alu_src_b  out  2  00 = rs2, 01 = immediate, 10 = constant 4.
- alu_op  out  2  00 = add, 01 = subtract, 10 = decode by funct.
- reg_write  out  1  register file write enable.
- state  out  4  current state encoding (debug).
- err_illegal  out  1  sticky: unsupported opcode seen.
- err_timeout  out  1  sticky: memory watchdog expired.
- retired  out  CNT_W  instructions retired, wraps modulo 2^CNT_W.

## Operation
- State encoding (4 bits): FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, EXECI=7, ALUWB=8, BEQ=9, JAL=10. Encodings 11–15 return to FETCH on the next cycle.
- Outputs are combinational from state, with the gating by `mem_ready` and `zero` listed below. Any output not listed for a state is 0.
- FETCH: `adr_src`=0, `mem_read`=1, `alu_src_a`=00, `alu_src_b`=10, `alu_op`=00, `result_src`=10, `ir_write`=`pc_write`=`mem_ready`.
  - On `mem_ready` the next state is DECODE; otherwise the FSM stays in FETCH.
- DECODE: `alu_src_a`=01, `alu_src_b`=01, `alu_op`=00 (computes the branch target). Next state by opcode:
  - 0000011 (lw) or 0100011 (sw) → MEMADR
  - 0110011 (R-type) → EXECR
  - 0010011 (I-type ALU) → EXECI
  - 1100011 (beq) → BEQ
  - 1101111 (jal) → JAL
  - any other opcode → FETCH, with `err_illegal` set.
- MEMADR: `alu_src_a`=10, `alu_src_b`=01, `alu_op`=00. Next state is MEMREAD for lw, otherwise MEMWRITE.
- MEMREAD: `adr_src`=1, `mem_read`=1. Waits for `mem_ready`, then goes to MEMWB.
- MEMWB: `result_src`=01, `reg_write`=1. Next state is FETCH.
- MEMWRITE: `adr_src`=1, `mem_write`=1. Waits for `mem_ready`, then goes to FETCH.
- EXECR: `alu_src_a`=10, `alu_src_b`=00, `alu_op`=10. Next state is ALUWB.
- EXECI: `alu_src_a`=10, `alu_src_b`=01, `alu_op`=10. Next state is ALUWB.
- ALUWB: `result_src`=00, `reg_write`=1. Next state is FETCH.
- BEQ: `alu_src_a`=10, `alu_src_b`=00, `alu_op`=01, `result_src`=00, `pc_write`=`zero`. Next state is FETCH.
- JAL: `alu_src_a`=01, `alu_src_b`=10, `alu_op`=00, `result_src`=00, `pc_write`=1. Next state is ALUWB (writes PC+4 to rd).
- Watchdog, applied in the wait states FETCH, MEMREAD and MEMWRITE:
  - `wait_cnt` clears on every state change.
  - `wait_cnt` increments each cycle spent in a wait state with `mem_ready`=0.
  - If MEM_TIMEOUT>0, `wait_cnt`==MEM_TIMEOUT-1 and `mem_ready`=0: next state is FETCH and `err_timeout` is set. No `pc_write`, `ir_write` or `reg_write` is issued for the aborted access.
  - If `mem_ready` arrives in that same last cycle, `mem_ready` wins and no timeout is flagged.
- `retired` increments by 1 on each transition into FETCH from MEMWB, MEMWRITE (with `mem_ready`), ALUWB or BEQ. Illegal and timed-out instructions do not count.
- Error flags are cleared only by `rst`.

## Timing
- Reset, asynchronous and immediate: state=FETCH, `wait_cnt`=0, `retired`=0, `err_illegal`=0, `err_timeout`=0.
- While in reset the outputs show FETCH values: `mem_read`=1, `alu_src_b`=10, `result_src`=10, `ir_write`=`pc_write`=`mem_ready`, all others 0.
- If reset is asserted mid-instruction, the instruction is abandoned: no further `reg_write` or `mem_write` is issued and it is not counted.
- Minimum latencies with `mem_ready` held at 1:

| Instruction | Cycles |
|---|---|
| lw | 5 |
| sw | 4 |
| R-type | 4 |
| I-type ALU | 4 |
| jal | 4 |
| beq | 3 |

- Each wait state adds one cycle per cycle that `mem_ready` is low, up to MEM_TIMEOUT cycles in that state.
- With MEM_HANDSHAKE=0, all latencies are fixed at the minimum and the watchdog never fires.

## Test plan
- Reset, then `mem_ready`=1 and opcode 0110011: state sequence 0,1,6,8,0; `reg_write`=1 only in the state-8 cycle; `retired`=1.
- lw (0000011) with `mem_ready` low for 3 cycles in MEMREAD: sequence 0,1,2,3,3,3,3,4,0 (9 cycles); `result_src`=01 in MEMWB; `retired` increments once.
- beq with `zero`=1, then beq with `zero`=0: `pc_write`=1 in the BEQ state only for the first; each takes 3 cycles; `retired`=2.
- Opcode 1111111: DECODE→FETCH, `err_illegal`=1 and stays 1 across 3 later R-type instructions; `retired` is unchanged by the illegal one.
- MEM_TIMEOUT=4 with sw and `mem_ready` stuck at 0: exactly 4 MEMWRITE cycles, then FETCH with `err_timeout`=1 and no count. A variant with `mem_ready`=1 on the 4th cycle completes normally with `err_timeout`=0.
- Assert `rst` during MEMWB: `state`=0 and `retired`=0 immediately, `reg_write`=0 from that edge on; CNT_W=4 wrap check: 16 retirements return `retired` to 0.

Source files
------------

// File: rtl/riscv_multicycle_control.sv
// riscv_multicycle_control: multi-cycle RV32I main control FSM with memory watchdog, sticky errors and retire counter
module riscv_multicycle_control #(
  parameter int MEM_HANDSHAKE = 1,
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             adr_src,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic [1:0]       result_src,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic             reg_write,
  output logic [3:0]       state,
  output logic             err_illegal,
  output logic             err_timeout,
  output logic [CNT_W-1:0] retired
);
  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BEQ, JAL
  } state_t;
  localparam logic [6:0] OP_LW = 7'b0000011, OP_SW = 7'b0100011, OP_R = 7'b0110011,
                         OP_I = 7'b0010011, OP_B = 7'b1100011, OP_J = 7'b1101111;
  localparam int WW = MEM_TIMEOUT > 2 ? $clog2(MEM_TIMEOUT) : 1;
  state_t st, nxt;
  logic [WW-1:0] wait_cnt;
  logic rdy, wait_st, tmo, ret;
  assign rdy = MEM_HANDSHAKE != 0 ? mem_ready : 1'b1;
  assign wait_st = st inside {FETCH, MEMREAD, MEMWRITE};
  assign tmo = (MEM_TIMEOUT > 0) && wait_st && !rdy && wait_cnt == WW'(MEM_TIMEOUT - 1);
  assign ret = nxt == FETCH && (st inside {MEMWB, ALUWB, BEQ} || (st == MEMWRITE && rdy));
  assign state = st;
  always_comb begin
    nxt = FETCH;
    case (st)
      FETCH:    nxt = rdy ? DECODE : FETCH;
      DECODE:   nxt = (opcode == OP_LW || opcode == OP_SW) ? MEMADR :
                      opcode == OP_R ? EXECR : opcode == OP_I ? EXECI :
                      opcode == OP_B ? BEQ : opcode == OP_J ? JAL : FETCH;
      MEMADR:   nxt = opcode == OP_LW ? MEMREAD : MEMWRITE;
      MEMREAD:  nxt = rdy ? MEMWB : MEMREAD;
      MEMWRITE: nxt = rdy ? FETCH : MEMWRITE;
      EXECR:    nxt = ALUWB;
      EXECI:    nxt = ALUWB;
      JAL:      nxt = ALUWB;
      default:  nxt = FETCH;
    endcase
    if (tmo) nxt = FETCH;
  end
  always_comb begin
    pc_write = 1'b0;
    adr_src = 1'b0;
    mem_read = 1'b0;
    mem_write = 1'b0;
    ir_write = 1'b0;
    result_src = 2'b00;
    alu_src_a = 2'b00;
    alu_src_b = 2'b00;
    alu_op = 2'b00;
    reg_write = 1'b0;
    case (st)
      FETCH:    begin mem_read = 1'b1; alu_src_b = 2'b10; result_src = 2'b10; ir_write = rdy; pc_write = rdy; end
      DECODE:   begin alu_src_a = 2'b01; alu_src_b = 2'b01; end
      MEMADR:   begin alu_src_a = 2'b10; alu_src_b = 2'b01; end
      MEMREAD:  begin adr_src = 1'b1; mem_read = 1'b1; end
      MEMWB:    begin result_src = 2'b01; reg_write = 1'b1; end
      MEMWRITE: begin adr_src = 1'b1; mem_write = 1'b1; end
      EXECR:    begin alu_src_a = 2'b10; alu_op = 2'b10; end
      EXECI:    begin alu_src_a = 2'b10; alu_src_b = 2'b01; alu_op = 2'b10; end
      ALUWB:    reg_write = 1'b1;
      BEQ:      begin alu_src_a = 2'b10; alu_op = 2'b01; pc_write = zero; end
      JAL:      begin alu_src_a = 2'b01; alu_src_b = 2'b10; pc_write = 1'b1; end
      default:  ;
    endcase
  end
  // a timeout in FETCH keeps the state, so the counter is cleared explicitly
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st <= FETCH;
      wait_cnt <= '0;
      retired <= '0;
      err_illegal <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      st <= nxt;
      wait_cnt <= (nxt != st || tmo) ? '0 : wait_cnt + WW'(1);
      err_illegal <= err_illegal | (st == DECODE && nxt == FETCH);
      err_timeout <= err_timeout | tmo;
      if (ret) retired <= retired + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_riscv_multicycle_control.sv
// tb_riscv_multicycle_control: randomized scoreboard bench against an instruction-level trace model
module tb_riscv_multicycle_control;
  localparam int T = 4;
  localparam logic [3:0] S_FETCH = 4'd0, S_DECODE = 4'd1, S_MEMADR = 4'd2, S_MEMREAD = 4'd3,
    S_MEMWB = 4'd4, S_MEMWRITE = 4'd5, S_EXECR = 4'd6, S_EXECI = 4'd7, S_ALUWB = 4'd8,
    S_BEQ = 4'd9, S_JAL = 4'd10;
  localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011,
    IT = 7'b0010011, BQ = 7'b1100011, JL = 7'b1101111;
  typedef struct packed {
    logic [3:0] st;
    logic pcw, adr, mr, mw, irw;
    logic [1:0] rs, sa, sb, op;
    logic rw, ei, et;
    logic [3:0] ret;
  } obs_t;
  logic clk = 1'b0, rst = 1'b1, zero = 1'b0, mem_ready = 1'b0;
  logic [6:0] opcode = '0;
  logic pc_write, adr_src, mem_read, mem_write, ir_write, reg_write, err_illegal, err_timeout;
  logic [1:0] result_src, alu_src_a, alu_src_b, alu_op;
  logic [3:0] state, retired;
  int checks = 0, passes = 0;
  obs_t exp_q[$];
  logic [3:0] m_ret = '0;
  bit m_ei = 1'b0, m_et = 1'b0;
  riscv_multicycle_control #(.MEM_HANDSHAKE(1), .MEM_TIMEOUT(T), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .pc_write(pc_write), .adr_src(adr_src), .mem_read(mem_read), .mem_write(mem_write),
    .ir_write(ir_write), .result_src(result_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .reg_write(reg_write), .state(state), .err_illegal(err_illegal),
    .err_timeout(err_timeout), .retired(retired)
  );
  always #5 clk = ~clk;
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  task automatic chk(string n, logic [31:0] got, logic [31:0] want);
    checks++;
    if (got === want) passes++;
    else $display("FAIL %s: got %h want %h at %0t", n, got, want, $time);
  endtask
  function automatic bit rb();
    return 1'($urandom_range(0, 1));
  endfunction
  // control word each state must present, with the registered status from the model
  function automatic obs_t ref_out(logic [3:0] s, bit r, bit z);
    obs_t o = '0;
    o.st = s;
    case (s)
      S_FETCH:    begin o.mr = 1; o.sb = 2; o.rs = 2; o.irw = r; o.pcw = r; end
      S_DECODE:   begin o.sa = 1; o.sb = 1; end
      S_MEMADR:   begin o.sa = 2; o.sb = 1; end
      S_MEMREAD:  begin o.adr = 1; o.mr = 1; end
      S_MEMWB:    begin o.rs = 1; o.rw = 1; end
      S_MEMWRITE: begin o.adr = 1; o.mw = 1; end
      S_EXECR:    begin o.sa = 2; o.op = 2; end
      S_EXECI:    begin o.sa = 2; o.sb = 1; o.op = 2; end
      S_ALUWB:    o.rw = 1;
      S_BEQ:      begin o.sa = 2; o.op = 1; o.pcw = z; end
      S_JAL:      begin o.sa = 1; o.sb = 2; o.pcw = 1; end
      default:    ;
    endcase
    o.ei = m_ei;
    o.et = m_et;
    o.ret = m_ret;
    return o;
  endfunction
  task automatic push(logic [3:0] s, bit r, bit z);
    mem_ready = r;
    zero = z;
    exp_q.push_back(ref_out(s, r, z));
  endtask
  task automatic emit(logic [3:0] s, bit r, bit z);
    push(s, r, z);
    @(posedge clk);
    #1;
  endtask
  task automatic wait_state(logic [3:0] s, int d, bit z, output bit ok);
    ok = 1'b0;
    for (int i = 0; i <= d; i++) begin
      if (i == d) begin
        emit(s, 1'b1, z);
        ok = 1'b1;
        return;
      end
      emit(s, 1'b0, z);
      if (i == T - 1) begin
        m_et = 1'b1;
        return;
      end
    end
  endtask
  task automatic instr(logic [6:0] op, bit z, int df, int dm);
    bit ok;
    opcode = op;
    wait_state(S_FETCH, df, z, ok);
    if (!ok) return;
    emit(S_DECODE, rb(), z);
    case (op)
      LW, SW: begin
        emit(S_MEMADR, rb(), z);
        wait_state(op == LW ? S_MEMREAD : S_MEMWRITE, dm, z, ok);
        if (!ok) return;
        if (op == LW) emit(S_MEMWB, rb(), z);
        m_ret++;
      end
      RT: begin emit(S_EXECR, rb(), z); emit(S_ALUWB, rb(), z); m_ret++; end
      IT: begin emit(S_EXECI, rb(), z); emit(S_ALUWB, rb(), z); m_ret++; end
      BQ: begin emit(S_BEQ, rb(), z); m_ret++; end
      JL: begin emit(S_JAL, rb(), z); emit(S_ALUWB, rb(), z); m_ret++; end
      default: m_ei = 1'b1;
    endcase
  endtask
  task automatic do_reset();
    bit r;
    r = rb();
    rst = 1'b1;
    mem_ready = r;
    #2;
    chk("rst_state", 32'(state), 0);
    chk("rst_retired", 32'(retired), 0);
    chk("rst_errs", {err_illegal, err_timeout}, 0);
    chk("rst_ctrl", {mem_read, alu_src_b, result_src, reg_write, mem_write, adr_src},
        {1'b1, 2'b10, 2'b10, 3'b000});
    chk("rst_irw_pcw", {ir_write, pc_write}, {r, r});
    @(posedge clk);
    #1;
    rst = 1'b0;
    m_ret = '0;
    m_ei = 1'b0;
    m_et = 1'b0;
  endtask
  task automatic rst_in_wb();
    opcode = LW;
    emit(S_FETCH, 1'b1, 1'b0);
    emit(S_DECODE, 1'b1, 1'b0);
    emit(S_MEMADR, 1'b1, 1'b0);
    emit(S_MEMREAD, 1'b1, 1'b0);
    push(S_MEMWB, 1'b1, 1'b0);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("wbrst_state", 32'(state), 0);
    chk("wbrst_retired", 32'(retired), 0);
    chk("wbrst_reg_write", 32'(reg_write), 0);
    @(posedge clk);
    #1;
    chk("wbrst_reg_write_after", 32'(reg_write), 0);
    rst = 1'b0;
    m_ret = '0;
    m_ei = 1'b0;
    m_et = 1'b0;
  endtask
  initial begin
    obs_t e, a;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = {state, pc_write, adr_src, mem_read, mem_write, ir_write, result_src, alu_src_a,
             alu_src_b, alu_op, reg_write, err_illegal, err_timeout, retired};
        chk($sformatf("cycle_st%0d", e.st), 32'(a), 32'(e));
      end
    end
  end
  initial begin
    logic [6:0] op;
    @(posedge clk);
    #1;
    do_reset();
    instr(RT, 1'b0, 0, 0);
    instr(LW, 1'b0, 0, 3);
    instr(BQ, 1'b1, 0, 0);
    instr(BQ, 1'b0, 0, 0);
    instr(7'b1111111, 1'b0, 0, 0);
    repeat (3) instr(RT, 1'b0, 0, 0);
    do_reset();
    instr(SW, 1'b0, 0, 3);
    instr(SW, 1'b0, 0, 100);
    instr(JL, 1'b0, 1, 0);
    instr(IT, 1'b1, 6, 0);
    instr(RT, 1'b0, 0, 0);
    rst_in_wb();
    repeat (17) instr(RT, 1'b0, 0, 0);
    for (int n = 0; n < 300; n++) begin
      if (n % 60 == 59) do_reset();
      case ($urandom_range(0, 6))
        0: op = LW;
        1: op = SW;
        2: op = RT;
        3: op = IT;
        4: op = BQ;
        5: op = JL;
        default: begin
          op = 7'($urandom);
          while (op inside {LW, SW, RT, IT, BQ, JL}) op = 7'($urandom);
        end
      endcase
      instr(op, rb(), ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 6)) : 0,
            ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 6)) : 0);
    end
    repeat (2) @(posedge clk);
    chk("drain", 32'(exp_q.size()), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
